// File: rtl/operand_reader_pkg.sv
// Shared types, widths and helpers for the operand byte reader.
package operand_reader_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    RDR_IDLE  = 1'b0,
    RDR_FETCH = 1'b1
  } rdr_state_t;

  // Limit a requested byte count to the widest operand the reader can build.
  function automatic int unsigned clamp_count(input int unsigned n, input int unsigned max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/operand_byte_reader_if.sv
// Request, FIFO and result signals of the operand byte reader.
// With OPERAND_READER_STALL_CNT_EN defined, the stall_cycles counter is added.
interface operand_byte_reader_if
  import operand_reader_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 4
);
  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
  localparam int unsigned OP_W  = BYTE_W * MAX_BYTES;

  logic              start;
  logic              flush;
  logic [CNT_W-1:0]  num_bytes;
  logic              sign_ext;
  logic              busy;
  logic              complete;
  logic [OP_W-1:0]   operand;
  logic [CNT_W-1:0]  bytes_read;
  logic              fifo_rd_en;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              fifo_empty;
`ifdef OPERAND_READER_STALL_CNT_EN
  logic [15:0]       stall_cycles;
`endif

  // Reader side
  modport slave (
`ifdef OPERAND_READER_STALL_CNT_EN
    output stall_cycles,
`endif
    input  start, flush, num_bytes, sign_ext, fifo_rd_data, fifo_empty,
    output busy, complete, operand, bytes_read, fifo_rd_en
  );

  // Requester / FIFO side
  modport master (
`ifdef OPERAND_READER_STALL_CNT_EN
    input  stall_cycles,
`endif
    output start, flush, num_bytes, sign_ext, fifo_rd_data, fifo_empty,
    input  busy, complete, operand, bytes_read, fifo_rd_en
  );

endinterface

// File: rtl/operand_extend.sv
// Zero/sign-extends the low i_count bytes of i_raw to the full operand width.
module operand_extend
  import operand_reader_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic [BYTE_W*MAX_BYTES-1:0] i_raw,
  input  logic [CNT_W-1:0]            i_count,
  input  logic                        i_sign_ext,
  output logic [BYTE_W*MAX_BYTES-1:0] o_operand
);

  logic w_sign;

  // Pick the MSB of the last valid byte; a zero count has no sign.
  always_comb begin
    w_sign = 1'b0;
    for (int k = 0; k < int'(MAX_BYTES); k++) begin
      if (i_count == CNT_W'(k + 1)) w_sign = i_raw[BYTE_W*k + BYTE_W - 1];
    end
  end

  // Keep valid bytes, fill the rest with the extension bit.
  always_comb begin
    o_operand = '0;
    for (int k = 0; k < int'(MAX_BYTES); k++) begin
      if (CNT_W'(k) < i_count) o_operand[BYTE_W*k +: BYTE_W] = i_raw[BYTE_W*k +: BYTE_W];
      else                     o_operand[BYTE_W*k +: BYTE_W] = {BYTE_W{i_sign_ext & w_sign}};
    end
  end

endmodule

// File: rtl/operand_byte_reader.sv
// Pulls up to MAX_BYTES little-endian bytes from the prefetch FIFO and
// presents them as one extended operand, completing with zero extra latency.
// Optional: OPERAND_READER_STALL_CNT_EN adds a saturating FIFO-stall counter.
module operand_byte_reader
  import operand_reader_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  operand_byte_reader_if.slave  bus
);

  localparam int unsigned OP_W = BYTE_W * MAX_BYTES;
  localparam logic [0:0] ST_IDLE  = RDR_IDLE;
  localparam logic [0:0] ST_FETCH = RDR_FETCH;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_tgt;
  logic             r_sext;
  logic [OP_W-1:0]  r_buf;
  logic [CNT_W-1:0] r_bytes_read;

  logic             w_start_ok;
  logic             w_active;
  logic [CNT_W-1:0] w_tgt;
  logic             w_sext;
  logic [CNT_W-1:0] w_cnt;
  logic             w_pop;
  logic             w_complete;
  logic [OP_W-1:0]  w_merged;
  logic [OP_W-1:0]  w_ext_in;
  logic [CNT_W-1:0] w_ext_cnt;
  logic             w_ext_sext;
  logic [OP_W-1:0]  w_operand;

  // Request decode: live inputs in the start cycle, latched values afterwards.
  always_comb begin
    w_start_ok = (r_state == ST_IDLE) & bus.start & ~bus.flush & ~reset;
    w_active   = w_start_ok | ((r_state == ST_FETCH) & ~reset);
    w_tgt      = w_start_ok ? CNT_W'(clamp_count(32'(bus.num_bytes), MAX_BYTES)) : r_tgt;
    w_sext     = w_start_ok ? bus.sign_ext : r_sext;
    w_cnt      = w_start_ok ? '0 : r_bytes_read;
    w_pop      = w_active & ~bus.flush & ~bus.fifo_empty & (w_cnt < w_tgt);
    w_complete = w_active & ~bus.flush &
                 ((w_tgt == '0) | (w_pop & (CNT_W'(w_cnt + CNT_W'(1)) == w_tgt)));
    w_merged   = w_start_ok ? '0 : r_buf;
    for (int k = 0; k < int'(MAX_BYTES); k++) begin
      if (w_pop && (w_cnt == CNT_W'(k))) w_merged[BYTE_W*k +: BYTE_W] = bus.fifo_rd_data;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_ok && !w_complete)  w_state_nxt = ST_FETCH;
      ST_FETCH: if (bus.flush || w_complete)    w_state_nxt = ST_IDLE;
      default:                                  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Request latch, byte buffer and byte count; held after completion for decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tgt        <= '0;
      r_sext       <= 1'b0;
      r_buf        <= '0;
      r_bytes_read <= '0;
    end else if (bus.flush) begin
      r_buf        <= '0;
      r_bytes_read <= '0;
    end else if (w_active) begin
      if (w_start_ok) begin
        r_tgt  <= w_tgt;
        r_sext <= w_sext;
      end
      r_buf        <= w_merged;
      r_bytes_read <= w_pop ? CNT_W'(w_cnt + CNT_W'(1)) : w_cnt;
    end
  end

  // Completing cycle shows the live byte merged in; otherwise the stored bytes.
  always_comb begin
    w_ext_in   = w_complete ? w_merged : r_buf;
    w_ext_cnt  = w_complete ? w_tgt    : r_bytes_read;
    w_ext_sext = w_complete ? w_sext   : r_sext;
  end

  operand_extend #(
    .MAX_BYTES (MAX_BYTES),
    .CNT_W     (CNT_W)
  ) u_extend (
    .i_raw      (w_ext_in),
    .i_count    (w_ext_cnt),
    .i_sign_ext (w_ext_sext),
    .o_operand  (w_operand)
  );

  assign bus.busy       = w_active & ~bus.flush & ~w_complete;
  assign bus.complete   = w_complete;
  assign bus.fifo_rd_en = w_pop;
  assign bus.operand    = w_operand;
  assign bus.bytes_read = r_bytes_read;

`ifdef OPERAND_READER_STALL_CNT_EN
  logic [15:0] r_stall;
  logic        w_stall;

  assign w_stall = w_active & ~bus.flush & bus.fifo_empty & ~w_complete;

  // Saturating count of FIFO-empty cycles in the current fetch.
  always_ff @(posedge clk) begin
    if (reset)                              r_stall <= 16'd0;
    else if (w_start_ok)                    r_stall <= w_stall ? 16'd1 : 16'd0;
    else if (w_stall && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
  end

  assign bus.stall_cycles = r_stall;
`endif

endmodule
